// File: rtl/tl_timer_if.sv
// ---------------------------------------------------------------------------
// tl_timer_if
//   Signal bundle between the traffic-light controller side and the interval
//   timer / car-sensor conditioner.
//
//   Signals:
//     st       start/restart timer pulse from the controller
//     car_raw  raw farm-road car sensor level (asynchronous to clk)
//     ts       short interval elapsed
//     tl       long interval elapsed
//     c        conditioned car-present level
//
//   Modports:
//     master   controller / stimulus side: drives st and car_raw, observes flags
//     slave    timer side: consumes st and car_raw, drives ts, tl and c
// ---------------------------------------------------------------------------
interface tl_timer_if;
    logic st;
    logic car_raw;
    logic ts;
    logic tl;
    logic c;

    modport master (
        output st,
        output car_raw,
        input  ts,
        input  tl,
        input  c
    );

    modport slave (
        input  st,
        input  car_raw,
        output ts,
        output tl,
        output c
    );
endinterface

// File: rtl/tl_timer.sv
// ---------------------------------------------------------------------------
// tl_timer
//   Interval timer and car-sensor conditioner for the highway/farm
//   traffic-light controller.
//
//   Timer: a saturating counter restarted by st. ts flags that SHORT_CYCLES
//   edges have elapsed since the restart (or reset release), tl flags that
//   LONG_CYCLES edges have elapsed. Both are decoded from the counter register
//   only, so they carry no combinational path from any input.
//
//   Car path (optional, macro TL_DEBOUNCE_EN):
//     defined   car_raw -> 2-flop synchronizer -> debounce FSM -> registered c.
//               c only changes after the synchronized level has differed from
//               c for DB_CYCLES consecutive edges.
//     undefined c follows car_raw combinationally (clean simulation stimulus).
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous active-high reset
//     bus    tl_timer_if.slave (st, car_raw in; ts, tl, c out)
//
//   Parameters:
//     SHORT_CYCLES  edges from restart until ts (>= 1)
//     LONG_CYCLES   edges from restart until tl (> SHORT_CYCLES, < 2**CW)
//     CW            counter width
//     DB_CYCLES     debounce stability window (>= 1), debounce build only
// ---------------------------------------------------------------------------
module tl_timer #(
    parameter int SHORT_CYCLES = 3,
    parameter int LONG_CYCLES  = 8,
    parameter int CW           = 4,
    parameter int DB_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       reset,
    tl_timer_if.slave  bus
);

    // Reject parameter sets that would make the flags meaningless or let the
    // counter wrap before it saturates.
    if (SHORT_CYCLES < 1 || LONG_CYCLES <= SHORT_CYCLES ||
        LONG_CYCLES >= (1 << CW) || DB_CYCLES < 1) begin : g_bad_params
        $error("tl_timer: illegal parameter combination");
    end

    localparam logic [CW-1:0] SHORT_V = CW'(SHORT_CYCLES);
    localparam logic [CW-1:0] LONG_V  = CW'(LONG_CYCLES);

    // -----------------------------------------------------------------------
    // Interval counter: cleared by st, otherwise counts up and sticks at
    // LONG_CYCLES so the flags stay high until the next restart.
    // -----------------------------------------------------------------------
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (bus.st) begin
            cnt_reg <= '0;
        end else if (cnt_reg < LONG_V) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bus.ts = (cnt_reg >= SHORT_V);
    assign bus.tl = (cnt_reg >= LONG_V);

    // -----------------------------------------------------------------------
    // Car-sensor conditioning
    // -----------------------------------------------------------------------
`ifdef TL_DEBOUNCE_EN
    localparam int DBW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    typedef enum logic {
        IDLE_LO,
        IDLE_HI
    } db_state_t;

    logic      sync1_reg;
    logic      car_s_reg;
    db_state_t state_reg;
    logic [DBW-1:0] dbc_reg;
    logic      c_reg;

    // car_raw is asynchronous; two flops before anything decides on it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            car_s_reg <= 1'b0;
        end else begin
            sync1_reg <= bus.car_raw;
            car_s_reg <= sync1_reg;
        end
    end

    // dbc counts consecutive edges on which car_s disagrees with c. The edge
    // that would make the count reach DB_CYCLES flips c instead, so the flip
    // lands exactly DB_CYCLES disagreeing edges after the first one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE_LO;
            dbc_reg   <= '0;
            c_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE_LO: begin
                    if (car_s_reg) begin
                        if (dbc_reg == DB_LAST) begin
                            state_reg <= IDLE_HI;
                            c_reg     <= 1'b1;
                            dbc_reg   <= '0;
                        end else begin
                            dbc_reg   <= dbc_reg + 1'b1;
                        end
                    end else begin
                        dbc_reg <= '0;
                    end
                end
                IDLE_HI: begin
                    if (!car_s_reg) begin
                        if (dbc_reg == DB_LAST) begin
                            state_reg <= IDLE_LO;
                            c_reg     <= 1'b0;
                            dbc_reg   <= '0;
                        end else begin
                            dbc_reg   <= dbc_reg + 1'b1;
                        end
                    end else begin
                        dbc_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE_LO;
                    dbc_reg   <= '0;
                    c_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.c = c_reg;
`else
    assign bus.c = bus.car_raw;
`endif

endmodule

// File: tb/tb_tl_timer.sv
// ---------------------------------------------------------------------------
// tb_tl_timer
//   Self-checking bench for tl_timer. A driver issues one input vector per
//   clock and pushes the reference model's expected (ts, tl, c) into a queue;
//   a monitor pops and compares on every falling edge. Asynchronous reset
//   behaviour is checked directly. Works with and without TL_DEBOUNCE_EN.
// ---------------------------------------------------------------------------
module tb_tl_timer;

    localparam int SHORT = 3;
    localparam int LONG  = 8;
    localparam int CW    = 4;
    localparam int DB    = 4;
`ifdef TL_DEBOUNCE_EN
    localparam bit DEBOUNCE = 1'b1;
`else
    localparam bit DEBOUNCE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tl_timer_if bus ();

    tl_timer #(
        .SHORT_CYCLES (SHORT),
        .LONG_CYCLES  (LONG),
        .CW           (CW),
        .DB_CYCLES    (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit ts;
        bit tl;
        bit c;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: elapsed edges since the last restart, and the car level
    // derived from the rule "c flips after DB consecutive synchronized samples
    // that disagree with it"; a synchronized sample is car_raw two edges ago.
    int elapsed;
    bit c_m;
    int run;
    bit raw_hist[$];

    task automatic model_reset();
        elapsed = 0;
        c_m     = 1'b0;
        run     = 0;
        raw_hist.delete();
    endtask

    task automatic model_edge(input bit st_v, input bit raw_v);
        bit s;
        elapsed = st_v ? 0 : elapsed + 1;
        if (DEBOUNCE) begin
            s = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 1'b0;
            if (s != c_m) begin
                run++;
                if (run == DB) begin
                    c_m = ~c_m;
                    run = 0;
                end
            end else begin
                run = 0;
            end
            raw_hist.push_back(raw_v);
            if (raw_hist.size() > 4) void'(raw_hist.pop_front());
        end else begin
            c_m = raw_v;
        end
    endtask

    task automatic check(input string name, input bit act, input bit exp_v, input int at);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0b expected %0b", name, at, act, exp_v);
        end
    endtask

    // One clock of stimulus; inputs change just after the falling edge so the
    // monitor's sample on that falling edge still sees the previous vector.
    task automatic step(input bit st_v, input bit raw_v);
        exp_t e;
        @(negedge clk);
        #1;
        bus.st      = st_v;
        bus.car_raw = raw_v;
        @(posedge clk);
        cyc++;
        model_edge(st_v, raw_v);
        e.ts  = (elapsed >= SHORT);
        e.tl  = (elapsed >= LONG);
        e.c   = c_m;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic run_steps(input int n, input bit st_v, input bit raw_v);
        for (int i = 0; i < n; i++) step(st_v, raw_v);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        reset  = 1'b1;
        bus.st = 1'b0;
        #1;
        check({name, "_ts"}, bus.ts, 1'b0, cyc);
        check({name, "_tl"}, bus.tl, 1'b0, cyc);
        check({name, "_c"},  bus.c,  DEBOUNCE ? 1'b0 : bus.car_raw, cyc);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ts", bus.ts, e.ts, e.cyc);
            check("tl", bus.tl, e.tl, e.cyc);
            check("c",  bus.c,  e.c,  e.cyc);
        end
    end

    initial begin
        bit raw_r;
        bit st_r;

        bus.st      = 1'b0;
        bus.car_raw = 1'b0;
        reset       = 1'b1;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ts", bus.ts, 1'b0, cyc);
        check("rst_tl", bus.tl, 1'b0, cyc);
        check("rst_c",  bus.c,  1'b0, cyc);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Free run from reset, then 20+ cycles of saturation
        run_steps(30, 1'b0, 1'b0);
        $display("scenario reset_release: cycles up to %0d", cyc);

        // Single restart pulse after saturation
        step(1'b1, 1'b0);
        run_steps(12, 1'b0, 1'b0);
        $display("scenario single_pulse: cycles up to %0d", cyc);

        // st held for five cycles
        run_steps(5, 1'b1, 1'b0);
        run_steps(10, 1'b0, 1'b0);
        $display("scenario st_held: cycles up to %0d", cyc);

        // Re-issued pulse at cnt = 2
        step(1'b1, 1'b0);
        run_steps(2, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        run_steps(10, 1'b0, 1'b0);
        $display("scenario repulse: cycles up to %0d", cyc);

        // Car glitch of 3 cycles, then a held car
        run_steps(3, 1'b0, 1'b1);
        run_steps(10, 1'b0, 1'b0);
        run_steps(10, 1'b0, 1'b1);
        $display("scenario car_debounce: cycles up to %0d", cyc);

        // Reset at cnt = 5 with car present, then replay the free run
        step(1'b1, 1'b1);
        run_steps(5, 1'b0, 1'b1);
        async_reset("midrst");
        run_steps(14, 1'b0, 1'b1);
        $display("scenario mid_reset: cycles up to %0d", cyc);

        // Randomized traffic: sparse restarts, car level in runs of varied length
        raw_r = 1'b1;
        for (int i = 0; i < 400; i++) begin
            st_r = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 5) == 0) raw_r = ~raw_r;
            step(st_r, raw_r);
            if (i == 200) async_reset("randrst");
        end
        $display("scenario random: cycles up to %0d", cyc);

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
